// File: rtl/snes_joypad_reader_pkg.sv
// rtl/snes_joypad_reader_pkg.sv - shared joypad constants for the reader and display/debug consumers
package snes_joypad_reader_pkg;

   // Button bit positions within joypad_state (0 = pressed)
   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

   // Word geometry: 16 serial bits, one per clock pulse
   localparam int JOY_BITS   = 16;
   localparam int JOY_PULSES = 16;

   // Value reported when nothing is pressed or no controller is attached
   localparam logic [JOY_BITS-1:0] JOY_RELEASED = 16'hFFFF;

   // Active-high view of one button for consumers of joypad_state
   function automatic logic btn_pressed(input logic [JOY_BITS-1:0] state, input int idx);
      return ~state[idx];
   endfunction

endpackage

// File: rtl/snes_joypad_reader_if.sv
// rtl/snes_joypad_reader_if.sv - controller pad signals and decoded button word
interface snes_joypad_reader_if;
   import snes_joypad_reader_pkg::*;

   logic                joy_latch;
   logic                joy_clk;
   logic                joy_data;
   logic [JOY_BITS-1:0] joypad_state;
   logic                state_valid;

   // Reader side: drives the pad strobes and publishes the button word
   modport master (
      output joy_latch,
      output joy_clk,
      output joypad_state,
      output state_valid,
      input  joy_data
   );

   // Controller/consumer side
   modport slave (
      input  joy_latch,
      input  joy_clk,
      input  joypad_state,
      input  state_valid,
      output joy_data
   );

endinterface

// File: rtl/snes_joypad_reader_sync2.sv
// rtl/snes_joypad_reader_sync2.sv - two-flop synchronizer for asynchronous pad inputs
module sync2 #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture; both stages take the idle level of the pad during reset
   always_ff @(posedge clock) begin
      if (reset) begin
         r_meta <= RESET_VALUE;
         r_sync <= RESET_VALUE;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/snes_joypad_reader.sv
// rtl/snes_joypad_reader.sv - periodic SNES controller poller producing a 16-bit button word
module snes_joypad_reader
   import snes_joypad_reader_pkg::*;
#(
   parameter int HALF_CYCLES = 200,
   parameter int POLL_CYCLES = 555000
) (
   input  logic                 clock,
   input  logic                 reset,
   snes_joypad_reader_if.master io_joy
);

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      SETTLE,
      CLK_LOW,
      CLK_HIGH,
      DONE
   } state_t;

   // Phase lengths expressed as the final value of the shared phase counter
   localparam logic [31:0] L_POLL_LAST  = 32'(POLL_CYCLES - 1);
   localparam logic [31:0] L_LATCH_LAST = 32'(2 * HALF_CYCLES - 1);
   localparam logic [31:0] L_HALF_LAST  = 32'(HALF_CYCLES - 1);
   localparam logic [4:0]  L_LAST_PULSE = 5'(JOY_PULSES);

   state_t              r_state;
   logic [31:0]         r_count;
   logic [4:0]          r_pulse;
   logic [JOY_BITS-1:0] r_shift;
   logic [JOY_BITS-1:0] r_joypad_state;
   logic                r_latch;
   logic                r_clk;
   logic                r_valid;
   logic                w_data;
   logic                w_phase_end;

   sync2 #(
      .RESET_VALUE (1'b1)
   ) u_data_sync (
      .clock   (clock),
      .reset   (reset),
      .i_async (io_joy.joy_data),
      .o_sync  (w_data)
   );

   // Flag the last cycle of the current phase
   always_comb begin
      w_phase_end = 1'b0;
      case (r_state)
         IDLE:     w_phase_end = (r_count == L_POLL_LAST);
         LATCH:    w_phase_end = (r_count == L_LATCH_LAST);
         SETTLE,
         CLK_LOW,
         CLK_HIGH: w_phase_end = (r_count == L_HALF_LAST);
         DONE:     w_phase_end = 1'b1;
         default:  w_phase_end = 1'b1;
      endcase
   end

   // Transaction sequencer: outputs are registered alongside the state they belong to
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= IDLE;
         r_count        <= '0;
         r_pulse        <= '0;
         r_shift        <= '0;
         r_joypad_state <= JOY_RELEASED;
         r_latch        <= 1'b0;
         r_clk          <= 1'b1;
         r_valid        <= 1'b0;
      end else begin
         r_count <= w_phase_end ? '0 : r_count + 32'd1;
         case (r_state)
            IDLE: begin
               if (w_phase_end) begin
                  r_state <= LATCH;
                  r_latch <= 1'b1;
               end
            end
            LATCH: begin
               if (w_phase_end) begin
                  r_state <= SETTLE;
                  r_latch <= 1'b0;
               end
            end
            SETTLE: begin
               // Bit 0 is on the wire as soon as the latch drops
               if (w_phase_end) begin
                  r_shift <= {w_data, r_shift[JOY_BITS-1:1]};
                  r_state <= CLK_LOW;
                  r_clk   <= 1'b0;
                  r_pulse <= 5'd1;
               end
            end
            CLK_LOW: begin
               if (w_phase_end) begin
                  r_state <= CLK_HIGH;
                  r_clk   <= 1'b1;
               end
            end
            CLK_HIGH: begin
               if (w_phase_end) begin
                  if (r_pulse == L_LAST_PULSE) begin
                     // Final pulse carries no data; publish the complete word at once
                     r_state        <= DONE;
                     r_joypad_state <= r_shift;
                     r_valid        <= 1'b1;
                  end else begin
                     r_shift <= {w_data, r_shift[JOY_BITS-1:1]};
                     r_pulse <= r_pulse + 5'd1;
                     r_state <= CLK_LOW;
                     r_clk   <= 1'b0;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_pulse <= '0;
            end
            default: begin
               r_state <= IDLE;
               r_latch <= 1'b0;
               r_clk   <= 1'b1;
               r_valid <= 1'b0;
               r_pulse <= '0;
            end
         endcase
      end
   end

   assign io_joy.joy_latch    = r_latch;
   assign io_joy.joy_clk      = r_clk;
   assign io_joy.joypad_state = r_joypad_state;
   assign io_joy.state_valid  = r_valid;

endmodule

// File: tb/tb_snes_joypad_reader.sv
// tb/tb_snes_joypad_reader.sv - randomized scoreboard bench for snes_joypad_reader
module tb_snes_joypad_reader;
   import snes_joypad_reader_pkg::*;

   localparam int H = 4;
   localparam int P = 100;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic rst_q = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   snes_joypad_reader_if joy_if ();

   snes_joypad_reader #(
      .HALF_CYCLES (H),
      .POLL_CYCLES (P)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .io_joy (joy_if)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   // Controller model: parallel load while latch is high, shift out on each clock rise
   int          m_mode = 0;
   logic        m_tie = 1'b1;
   logic [15:0] m_pattern = 16'hF5A3;
   logic [15:0] m_sr = 16'hFFFF;

   always @(posedge joy_if.joy_latch or posedge joy_if.joy_clk) begin
      if (joy_if.joy_latch) m_sr = m_pattern;
      else                  m_sr = {1'b1, m_sr[15:1]};
   end

   assign joy_if.joy_data = (m_mode == 0) ? m_sr[0] : m_tie;

   function automatic logic [15:0] expected_word();
      return (m_mode == 0) ? m_pattern : {16{m_tie}};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard and waveform monitor
   logic [15:0] sb_q[$];
   logic [15:0] sb_last = 16'hFFFF;
   logic        prev_latch = 1'b0;
   logic        prev_clk = 1'b1;
   int          t0 = -1;
   int          rel_cyc = -1;
   int          last_fall = -1;
   int          pulses = 0;

   always @(negedge clock) begin
      logic        latch_rise, latch_fall, clk_fall, clk_rise;
      logic [15:0] exp_word;
      latch_rise = joy_if.joy_latch && !prev_latch;
      latch_fall = !joy_if.joy_latch && prev_latch;
      clk_fall   = !joy_if.joy_clk && prev_clk;
      clk_rise   = joy_if.joy_clk && !prev_clk;
      if (rst_q) begin
         check("reset_latch", 32'(joy_if.joy_latch), 32'd0);
         check("reset_clk", 32'(joy_if.joy_clk), 32'd1);
         check("reset_state", 32'(joy_if.joypad_state), 32'hFFFF);
         check("reset_valid", 32'(joy_if.state_valid), 32'd0);
         sb_q.delete();
         sb_last   = 16'hFFFF;
         t0        = -1;
         last_fall = -1;
         pulses    = 0;
      end else begin
         if (latch_rise) begin
            if (rel_cyc >= 0) check("latch_after_release", 32'(cyc - rel_cyc), 32'(P));
            rel_cyc = -1;
            if (t0 >= 0) check("next_latch", 32'(cyc - t0), 32'(35 * H + 1 + P));
            t0        = cyc;
            pulses    = 0;
            last_fall = -1;
            sb_q.push_back(expected_word());
         end
         if (latch_fall && t0 >= 0) check("latch_width", 32'(cyc - t0), 32'(2 * H));
         if (clk_fall) begin
            pulses++;
            if (last_fall >= 0) check("clk_period", 32'(cyc - last_fall), 32'(2 * H));
            last_fall = cyc;
         end
         if (clk_rise && last_fall >= 0) check("clk_low_width", 32'(cyc - last_fall), 32'(H));
         if (joy_if.state_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid actual=1 required=0");
            end else begin
               exp_word = sb_q.pop_front();
               check("joypad_state", 32'(joy_if.joypad_state), 32'(exp_word));
               sb_last = exp_word;
            end
            check("valid_time", 32'(cyc - t0), 32'(35 * H));
            check("pulse_count", 32'(pulses), 32'(JOY_PULSES));
         end else begin
            check("state_hold", 32'(joy_if.joypad_state), 32'(sb_last));
            check("valid_low", 32'(joy_if.state_valid), 32'd0);
         end
      end
      prev_latch = joy_if.joy_latch;
      prev_clk   = joy_if.joy_clk;
   end

   task automatic wait_valid(input string what);
      bit seen = 0;
      for (int n = 0; n < 600 && !seen; n++) begin
         @(negedge clock);
         seen = joy_if.state_valid;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL timeout_%s actual=no_valid required=valid", what);
      end
   endtask

   initial begin
      bit hit;
      m_mode    = 0;
      m_pattern = 16'hF5A3;
      repeat (3) @(negedge clock);
      reset   = 1'b0;
      rel_cyc = cyc;

      // Known pattern, then randomized button words
      wait_valid("f5a3");
      for (int i = 0; i < 6; i++) begin
         m_pattern = 16'($urandom);
         wait_valid("random");
      end

      // Disconnected controller and all-pressed line
      m_mode = 1;
      m_tie  = 1'b1;
      wait_valid("tie1_a");
      wait_valid("tie1_b");
      m_tie = 1'b0;
      wait_valid("tie0_a");
      wait_valid("tie0_b");

      // Line activity during IDLE must not disturb the published word
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         m_tie = 1'($urandom);
      end
      m_mode    = 0;
      m_pattern = 16'($urandom);
      wait_valid("after_toggle");

      // Abort a transaction during pulse 7
      m_pattern = 16'h0000;
      hit = 0;
      for (int n = 0; n < 600 && !hit; n++) begin
         @(negedge clock);
         hit = (pulses == 7) && !joy_if.joy_clk;
      end
      check("reached_pulse7", 32'(hit), 32'd1);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset   = 1'b0;
      rel_cyc = cyc;
      begin
         int rel_snapshot;
         rel_snapshot = cyc;
         m_pattern    = 16'($urandom);
         wait_valid("after_abort");
         check("valid_after_abort", 32'(cyc - rel_snapshot), 32'(P + 35 * H));
      end
      wait_valid("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
